exu_alu_issue_sched: RTL and testbench

Out-of-order issue scheduler that sits between rename/dispatch (idu) and the single-cycle ALU execution unit (exu).
- Buffers up to DEPTH dispatched ALU µops.
- Tracks source-operand readiness by physical-register tag, woken by writeback broadcasts.
- Issues at most one ready µop per cycle, oldest first, to the ALU input stage.
- Payload (opcode, funct7, funct3, pc, imm, pdst and their valids) is carried opaque as PAYLOAD_W bits.

---
 rtl/exu_alu_issue_sched.sv | 163 ++++++++++++++++
 tb/tb_exu_alu_issue_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_issue_sched.sv
// Out-of-order ALU issue scheduler: holds dispatched uops, wakes sources on writeback
// broadcasts and issues the oldest ready uop each cycle through a registered output stage.
module exu_alu_issue_sched #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 160
) (
    input  logic                 clk,
    input  logic                 rst_clk,
    input  logic                 rtu_global_flush,
    input  logic                 idu_sched_dis_vld,
    input  logic [3:0]           idu_sched_dis_iid,
    input  logic                 idu_sched_dis_psrc1_vld,
    input  logic [5:0]           idu_sched_dis_psrc1,
    input  logic                 idu_sched_dis_psrc1_rdy,
    input  logic                 idu_sched_dis_psrc2_vld,
    input  logic [5:0]           idu_sched_dis_psrc2,
    input  logic                 idu_sched_dis_psrc2_rdy,
    input  logic [PAYLOAD_W-1:0] idu_sched_dis_payload,
    output logic                 sched_idu_full,
    input  logic                 wb0_vld,
    input  logic [5:0]           wb0_preg,
    input  logic                 wb1_vld,
    input  logic [5:0]           wb1_preg,
    output logic                 sched_exu_alu_vld,
    output logic [3:0]           sched_exu_alu_iid,
    output logic [5:0]           sched_exu_alu_psrc1,
    output logic [5:0]           sched_exu_alu_psrc2,
    output logic [PAYLOAD_W-1:0] sched_exu_alu_payload
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]     vld_q, vld_d;
    logic [DEPTH-1:0]     rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [3:0]           iid_q  [DEPTH];
    logic [3:0]           iid_d  [DEPTH];
    logic [5:0]           src1_q [DEPTH];
    logic [5:0]           src1_d [DEPTH];
    logic [5:0]           src2_q [DEPTH];
    logic [5:0]           src2_d [DEPTH];
    logic [PAYLOAD_W-1:0] pl_q   [DEPTH];
    logic [PAYLOAD_W-1:0] pl_d   [DEPTH];
    // age_q[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0]     age_q  [DEPTH];
    logic [DEPTH-1:0]     age_d  [DEPTH];

    logic                 out_vld_q, out_vld_d;
    logic [3:0]           out_iid_q, out_iid_d;
    logic [5:0]           out_src1_q, out_src1_d;
    logic [5:0]           out_src2_q, out_src2_d;
    logic [PAYLOAD_W-1:0] out_pl_q, out_pl_d;

    logic [DEPTH-1:0]     req, gnt;
    logic                 dis_acc;
    logic [IDX_W-1:0]     alloc_idx;

    function automatic logic wake(input logic [5:0] tag, input logic v0, input logic [5:0] t0,
                                  input logic v1, input logic [5:0] t1);
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    assign sched_idu_full = &vld_q;
    assign dis_acc        = idu_sched_dis_vld && !sched_idu_full;

    always_comb begin
        req = vld_q & rdy1_q & rdy2_q;
        gnt = req;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
                if (req[j] && age_q[j][i]) gnt[i] = 1'b0;
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!vld_q[i]) alloc_idx = IDX_W'(i);
    end

    always_comb begin
        vld_d  = vld_q & ~gnt;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        iid_d  = iid_q;
        src1_d = src1_q;
        src2_d = src2_q;
        pl_d   = pl_q;
        age_d  = age_q;
        out_vld_d  = |gnt;
        out_iid_d  = '0;
        out_src1_d = '0;
        out_src2_d = '0;
        out_pl_d   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
                out_iid_d  = iid_q[i];
                out_src1_d = src1_q[i];
                out_src2_d = src2_q[i];
                out_pl_d   = pl_q[i];
            end
            if (vld_q[i] && wake(src1_q[i], wb0_vld, wb0_preg, wb1_vld, wb1_preg)) rdy1_d[i] = 1'b1;
            if (vld_q[i] && wake(src2_q[i], wb0_vld, wb0_preg, wb1_vld, wb1_preg)) rdy2_d[i] = 1'b1;
        end
        if (dis_acc) begin
            vld_d[alloc_idx]  = 1'b1;
            iid_d[alloc_idx]  = idu_sched_dis_iid;
            src1_d[alloc_idx] = idu_sched_dis_psrc1;
            src2_d[alloc_idx] = idu_sched_dis_psrc2;
            pl_d[alloc_idx]   = idu_sched_dis_payload;
            rdy1_d[alloc_idx] = !idu_sched_dis_psrc1_vld || idu_sched_dis_psrc1_rdy ||
                                wake(idu_sched_dis_psrc1, wb0_vld, wb0_preg, wb1_vld, wb1_preg);
            rdy2_d[alloc_idx] = !idu_sched_dis_psrc2_vld || idu_sched_dis_psrc2_rdy ||
                                wake(idu_sched_dis_psrc2, wb0_vld, wb0_preg, wb1_vld, wb1_preg);
            // Rewrite the new entry's whole row and column so stale age bits never survive reuse
            for (int j = 0; j < DEPTH; j++) begin
                age_d[alloc_idx][j] = 1'b0;
                age_d[j][alloc_idx] = vld_q[j];
            end
        end
        if (rtu_global_flush) begin
            vld_d      = '0;
            out_vld_d  = 1'b0;
            out_iid_d  = '0;
            out_src1_d = '0;
            out_src2_d = '0;
            out_pl_d   = '0;
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            vld_q      <= '0;
            out_vld_q  <= 1'b0;
            out_iid_q  <= '0;
            out_src1_q <= '0;
            out_src2_q <= '0;
            out_pl_q   <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            vld_q      <= vld_d;
            out_vld_q  <= out_vld_d;
            out_iid_q  <= out_iid_d;
            out_src1_q <= out_src1_d;
            out_src2_q <= out_src2_d;
            out_pl_q   <= out_pl_d;
            age_q      <= age_d;
        end
    end

    // Entry contents are qualified by vld_q, so they carry no reset
    always_ff @(posedge clk) begin
        rdy1_q <= rdy1_d;
        rdy2_q <= rdy2_d;
        iid_q  <= iid_d;
        src1_q <= src1_d;
        src2_q <= src2_d;
        pl_q   <= pl_d;
    end

    assign sched_exu_alu_vld     = out_vld_q;
    assign sched_exu_alu_iid     = out_iid_q;
    assign sched_exu_alu_psrc1   = out_src1_q;
    assign sched_exu_alu_psrc2   = out_src2_q;
    assign sched_exu_alu_payload = out_pl_q;

endmodule

// File: tb/tb_exu_alu_issue_sched.sv
// Bench for exu_alu_issue_sched: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the scheduler.
module tb_exu_alu_issue_sched;

    localparam int DEPTH = 4;
    localparam int PW    = 160;

    logic          clk = 1'b0;
    logic          rst_clk;
    logic          flush;
    logic          dis_vld;
    logic [3:0]    dis_iid;
    logic          p1_vld, p1_rdy, p2_vld, p2_rdy;
    logic [5:0]    p1, p2;
    logic [PW-1:0] dis_pl;
    logic          full;
    logic          wb0_vld, wb1_vld;
    logic [5:0]    wb0_preg, wb1_preg;
    logic          o_vld;
    logic [3:0]    o_iid;
    logic [5:0]    o_p1, o_p2;
    logic [PW-1:0] o_pl;

    exu_alu_issue_sched #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(flush),
        .idu_sched_dis_vld(dis_vld), .idu_sched_dis_iid(dis_iid),
        .idu_sched_dis_psrc1_vld(p1_vld), .idu_sched_dis_psrc1(p1), .idu_sched_dis_psrc1_rdy(p1_rdy),
        .idu_sched_dis_psrc2_vld(p2_vld), .idu_sched_dis_psrc2(p2), .idu_sched_dis_psrc2_rdy(p2_rdy),
        .idu_sched_dis_payload(dis_pl), .sched_idu_full(full),
        .wb0_vld(wb0_vld), .wb0_preg(wb0_preg), .wb1_vld(wb1_vld), .wb1_preg(wb1_preg),
        .sched_exu_alu_vld(o_vld), .sched_exu_alu_iid(o_iid),
        .sched_exu_alu_psrc1(o_p1), .sched_exu_alu_psrc2(o_p2), .sched_exu_alu_payload(o_pl)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue order is age order, oldest at the front
    typedef struct {
        logic [3:0]    iid;
        logic [5:0]    s1, s2;
        bit            r1, r2;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t          mq[$];
    logic          e_vld;
    logic [3:0]    e_iid;
    logic [5:0]    e_p1, e_p2;
    logic [PW-1:0] e_pl;

    function automatic bit hit(input logic [5:0] t);
        return (wb0_vld && wb0_preg == t) || (wb1_vld && wb1_preg == t);
    endfunction

    task automatic model_clear();
        mq.delete();
        e_vld = 0; e_iid = 0; e_p1 = 0; e_p2 = 0; e_pl = '0;
    endtask

    task automatic model_edge();
        int   g;
        bit   acc;
        ent_t e;
        acc = dis_vld && (mq.size() < DEPTH);
        if (flush) begin
            model_clear();
        end else begin
            g = -1;
            for (int i = 0; i < mq.size(); i++)
                if (g < 0 && mq[i].r1 && mq[i].r2) g = i;
            if (g >= 0) begin
                e_vld = 1; e_iid = mq[g].iid; e_p1 = mq[g].s1; e_p2 = mq[g].s2; e_pl = mq[g].pl;
                mq.delete(g);
            end else begin
                e_vld = 0; e_iid = 0; e_p1 = 0; e_p2 = 0; e_pl = '0;
            end
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (hit(e.s1)) e.r1 = 1;
                if (hit(e.s2)) e.r2 = 1;
                mq[i] = e;
            end
            if (acc) begin
                e.iid = dis_iid; e.s1 = p1; e.s2 = p2; e.pl = dis_pl;
                e.r1  = !p1_vld || p1_rdy || hit(p1);
                e.r2  = !p2_vld || p2_rdy || hit(p2);
                mq.push_back(e);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("vld", PW'(o_vld), PW'(e_vld));
        chk("iid", PW'(o_iid), PW'(e_iid));
        chk("psrc1", PW'(o_p1), PW'(e_p1));
        chk("psrc2", PW'(o_p2), PW'(e_p2));
        chk("payload", o_pl, e_pl);
        chk("full", PW'(full), PW'(mq.size() == DEPTH));
    endtask

    task automatic idle();
        dis_vld = 0; flush = 0; wb0_vld = 0; wb1_vld = 0;
    endtask

    function automatic logic [PW-1:0] rpl();
        logic [PW-1:0] p;
        for (int k = 0; k < PW / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic dis(input logic [3:0] iid, input logic v1, input logic [5:0] t1, input logic r1,
                       input logic v2, input logic [5:0] t2, input logic r2);
        dis_vld = 1; dis_iid = iid; p1_vld = v1; p1 = t1; p1_rdy = r1;
        p2_vld = v2; p2 = t2; p2_rdy = r2; dis_pl = rpl();
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [PW-1:0] pl_t1;

    initial begin
        idle();
        dis_iid = 0; p1_vld = 0; p1 = 0; p1_rdy = 0; p2_vld = 0; p2 = 0; p2_rdy = 0; dis_pl = '0;
        wb0_preg = 0; wb1_preg = 0;
        rst_clk = 0;
        model_clear();
        #2;
        chk("rst_vld", PW'(o_vld), '0);
        chk("rst_full", PW'(full), '0);
        chk("rst_iid", PW'(o_iid), '0);
        chk("rst_payload", o_pl, '0);
        #20 rst_clk = 1;

        // 1: ready uop issues two edges after dispatch with its payload
        dis(4'd3, 1, 6'd1, 1, 1, 6'd2, 1);
        pl_t1 = dis_pl;
        cyc();
        idle();
        cyc();
        chk("t1_vld", PW'(o_vld), PW'(1));
        chk("t1_iid", PW'(o_iid), PW'(3));
        chk("t1_payload", o_pl, pl_t1);
        drain(2);

        // 2: younger ready uop bypasses older waiting one; wakeup releases the older
        dis(4'd1, 1, 6'd10, 0, 0, 6'd0, 0);
        cyc();
        dis(4'd2, 1, 6'd11, 1, 1, 6'd12, 1);
        cyc();
        idle();
        cyc();
        chk("t2_first", PW'(o_iid), PW'(2));
        wb0_vld = 1; wb0_preg = 6'd10;
        cyc();
        chk("t2_gap", PW'(o_vld), PW'(0));
        idle();
        cyc();
        chk("t2_second", PW'(o_iid), PW'(1));
        drain(2);

        // 3: fill, drop a dispatch while full, free one entry by wakeup
        for (int i = 0; i < 4; i++) begin
            dis(4'(4 + i), 1, 6'(30 + i), 0, 0, 6'd0, 0);
            cyc();
        end
        chk("t3_full", PW'(full), PW'(1));
        dis(4'd8, 0, 6'd0, 0, 0, 6'd0, 0);
        cyc();
        chk("t3_drop_full", PW'(full), PW'(1));
        idle();
        wb1_vld = 1; wb1_preg = 6'd31;
        cyc();
        chk("t3_still_full", PW'(full), PW'(1));
        idle();
        cyc();
        chk("t3_free", PW'(full), PW'(0));
        chk("t3_iid", PW'(o_iid), PW'(5));
        wb0_vld = 1; wb0_preg = 6'd30; wb1_vld = 1; wb1_preg = 6'd32;
        cyc();
        idle();
        wb0_vld = 1; wb0_preg = 6'd33;
        cyc();
        drain(4);

        // 4: same-cycle wakeup at dispatch is captured
        dis(4'd5, 0, 6'd0, 0, 1, 6'd20, 0);
        wb1_vld = 1; wb1_preg = 6'd20;
        cyc();
        idle();
        cyc();
        chk("t4_vld", PW'(o_vld), PW'(1));
        chk("t4_iid", PW'(o_iid), PW'(5));
        drain(2);

        // 5: back-to-back ready uops issue in order
        dis(4'd7, 0, 6'd0, 0, 0, 6'd0, 0);
        cyc();
        dis(4'd8, 0, 6'd0, 0, 0, 6'd0, 0);
        cyc();
        chk("t5_7", PW'(o_iid), PW'(7));
        dis(4'd9, 0, 6'd0, 0, 0, 6'd0, 0);
        cyc();
        chk("t5_8", PW'(o_iid), PW'(8));
        idle();
        cyc();
        chk("t5_9", PW'(o_iid), PW'(9));
        drain(2);

        // 6: flush beats a simultaneous dispatch
        for (int i = 0; i < 3; i++) begin
            dis(4'(10 + i), 1, 6'(40 + i), 0, 0, 6'd0, 0);
            cyc();
        end
        dis(4'd13, 0, 6'd0, 0, 0, 6'd0, 0);
        flush = 1;
        cyc();
        chk("t6_vld", PW'(o_vld), PW'(0));
        chk("t6_full", PW'(full), PW'(0));
        drain(4);

        // Random traffic with a small tag space so wakeups land often
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 9) < 7)
                dis(4'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
            wb0_vld = 1'($urandom_range(0, 2) == 0); wb0_preg = 6'($urandom_range(0, 7));
            wb1_vld = 1'($urandom_range(0, 2) == 0); wb1_preg = 6'($urandom_range(0, 7));
            flush   = ($urandom_range(0, 49) == 0);
            cyc();
            if (c == 300) begin
                rst_clk = 0;
                #1;
                model_clear();
                chk("async_rst_vld", PW'(o_vld), '0);
                chk("async_rst_full", PW'(full), '0);
                rst_clk = 1;
            end
        end
        drain(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
